// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at the start edge and held pending until the busy count expires.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  function automatic logic [31:0] abs32(input logic [31:0] v);
    abs32 = v[31] ? 32'(-v) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    neg_if = neg ? 32'(-v) : v;
  endfunction

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_ok_q, pend_ok_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        dvsr;
  logic [31:0]        quo_u, rem_u;
  logic [31:0]        mag_a, mag_b, quo_m, rem_m, quo_s, rem_s;

  // A zero divisor is replaced by 1 so the datapath never yields X; the result is discarded.
  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    dvsr   = (b == 32'd0) ? 32'd1 : b;
    quo_u  = a / dvsr;
    rem_u  = a % dvsr;
    mag_a  = abs32(a);
    mag_b  = abs32(dvsr);
    quo_m  = mag_a / mag_b;
    rem_m  = mag_a % mag_b;
    quo_s  = neg_if(quo_m, a[31] ^ dvsr[31]);
    rem_s  = neg_if(rem_m, a[31]);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_ok_d = pend_ok_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
              pend_ok_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = S_RUN;
            end
            OP_MULTU: begin
              pend_hi_d = prod_u[63:32];
              pend_lo_d = prod_u[31:0];
              pend_ok_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = S_RUN;
            end
            OP_DIV: begin
              pend_hi_d = rem_s;
              pend_lo_d = quo_s;
              pend_ok_d = (b != 32'd0);
              cnt_d     = DIV_LOAD;
              state_d   = S_RUN;
            end
            OP_DIVU: begin
              pend_hi_d = rem_u;
              pend_lo_d = quo_u;
              pend_ok_d = (b != 32'd0);
              cnt_d     = DIV_LOAD;
              state_d   = S_RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          if (pend_ok_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_ok_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_ok_q <= pend_ok_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
